// File: rtl/cond_pkg.sv
// Shared constants and helpers for the input conditioner.
// Parameter-legality checks and counter sizing are based on these.
package cond_pkg;

    localparam int MIN_SYNC_STAGES = 2;

    // The counter only has to reach DEBOUNCE_CYCLES-1.
    // Sizing it for DEBOUNCE_CYCLES keeps the width at least 1 bit.
    function automatic int cnt_width(input int debounce_cycles);
        return $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchronizer with asynchronous reset.
// There is no logic between the flops, so the tools can place them together as a resolver chain.
module sync_chain
    import cond_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] s;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s <= {SYNC_STAGES{RESET_LEVEL}};
        else     s <= {s[SYNC_STAGES-2:0], din};
    end

    assign dout = s[SYNC_STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: a synchronizer followed by a consecutive-sample debounce stage.
// Outputs a registered stable level plus single-cycle rise and fall pulses.
module input_conditioner
    import cond_pkg::*;
#(
    parameter int   CHANNELS        = 4,
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);

    localparam int             CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("input_conditioner: SYNC_STAGES must be >= %0d", MIN_SYNC_STAGES);
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic          sample;
        logic [CW-1:0] cnt;
        logic          level_q;
        logic          rise_q;
        logic          fall_q;

        sync_chain #(
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_LEVEL (RESET_LEVEL)
        ) u_sync (
            .clk  (clk),
            .rst  (rst),
            .din  (din[i]),
            .dout (sample)
        );

        // NOTE: reset clears every state bit, so an in-flight count is dropped and cannot produce a pulse.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt     <= '0;
                level_q <= RESET_LEVEL;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sample == level_q) begin
                    cnt <= '0;
                end else if (cnt != CNT_LAST) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    level_q <= sample;
                    rise_q  <= sample;
                    fall_q  <= ~sample;
                    cnt     <= '0;
                end
            end
        end

        assign level[i] = level_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner.
// Covers a 2-stage/4-cycle instance and a 3-stage/1-cycle instance.
module tb_input_conditioner;

    logic       clk;
    logic       rst;
    logic [3:0] din,   level,   rise,   fall;
    logic [3:0] din_b, level_b, rise_b, fall_b;

    int n_cmp = 0;
    int n_err = 0;

    input_conditioner #(
        .CHANNELS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .level(level), .rise(rise), .fall(fall)
    );

    input_conditioner #(
        .CHANNELS(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .RESET_LEVEL(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .level(level_b), .rise(rise_b), .fall(fall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
        end
    endtask

    task automatic expect_a(input string tag, input logic [3:0] lv, input logic [3:0] r, input logic [3:0] f);
        check(tag, {level, rise, fall}, {lv, r, f});
    endtask

    task automatic expect_b(input string tag, input logic [3:0] lv, input logic [3:0] r, input logic [3:0] f);
        check(tag, {level_b, rise_b, fall_b}, {lv, r, f});
    endtask

    initial begin
        // Reset held with non-reset input pattern
        rst   = 1'b1;
        din   = 4'b1010;
        din_b = 4'b0000;
        tick(3);
        expect_a("reset_hold", 4'b0000, 4'b0000, 4'b0000);
        expect_b("reset_hold_b", 4'b0000, 4'b0000, 4'b0000);
        din = 4'b0000;
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) expect_a_after(k);

        // Clean rising step on channel 0
        din = 4'b0001;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            expect_a($sformatf("step_rise_wait%0d", k), 4'b0000, 4'b0000, 4'b0000);
        end
        tick(1);
        expect_a("step_rise", 4'b0001, 4'b0001, 4'b0000);
        tick(1);
        expect_a("step_rise_clear", 4'b0001, 4'b0000, 4'b0000);

        // Clean falling step on channel 0
        din = 4'b0000;
        tick(5);
        expect_a("step_fall_wait", 4'b0001, 4'b0000, 4'b0000);
        tick(1);
        expect_a("step_fall", 4'b0000, 4'b0000, 4'b0001);
        tick(1);
        expect_a("step_fall_clear", 4'b0000, 4'b0000, 4'b0000);

        // Three-cycle glitch on channel 1 must be rejected
        din = 4'b0010;
        tick(3);
        din = 4'b0000;
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            expect_a($sformatf("glitch3_%0d", k), 4'b0000, 4'b0000, 4'b0000);
        end

        // Four-cycle pulse on channel 1 is just long enough
        din = 4'b0010;
        tick(4);
        din = 4'b0000;
        tick(1);
        expect_a("pulse4_wait", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_a("pulse4_rise", 4'b0010, 4'b0010, 4'b0000);
        tick(1);
        expect_a("pulse4_rise_clear", 4'b0010, 4'b0000, 4'b0000);
        tick(2);
        expect_a("pulse4_hold", 4'b0010, 4'b0000, 4'b0000);
        tick(1);
        expect_a("pulse4_fall", 4'b0000, 4'b0000, 4'b0010);
        tick(1);
        expect_a("pulse4_fall_clear", 4'b0000, 4'b0000, 4'b0000);

        // All four channels rise together
        din = 4'b1111;
        tick(5);
        expect_a("all_rise_wait", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_a("all_rise", 4'b1111, 4'b1111, 4'b0000);
        tick(1);
        expect_a("all_rise_clear", 4'b1111, 4'b0000, 4'b0000);

        // Channels 3:2 fall while 1:0 hold
        din = 4'b0011;
        tick(5);
        expect_a("upper_fall_wait", 4'b1111, 4'b0000, 4'b0000);
        tick(1);
        expect_a("upper_fall", 4'b0011, 4'b0000, 4'b1100);
        tick(1);
        expect_a("upper_fall_clear", 4'b0011, 4'b0000, 4'b0000);

        // Return to idle
        din = 4'b0000;
        tick(6);
        expect_a("lower_fall", 4'b0000, 4'b0000, 4'b0011);
        tick(1);

        // Reset asserted mid-count on channel 2
        din = 4'b0100;
        tick(3);
        rst = 1'b1;
        tick(1);
        expect_a("midreset_1", 4'b0000, 4'b0000, 4'b0000);
        tick(3);
        expect_a("midreset_2", 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick(1);
            expect_a($sformatf("post_reset_wait%0d", k), 4'b0000, 4'b0000, 4'b0000);
        end
        tick(1);
        expect_a("post_reset_rise", 4'b0100, 4'b0100, 4'b0000);
        tick(1);
        expect_a("post_reset_rise_clear", 4'b0100, 4'b0000, 4'b0000);

        // Second instance: 3-stage synchronizer, no filtering
        din_b = 4'b0001;
        tick(3);
        expect_b("b_step_wait", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_b("b_step_rise", 4'b0001, 4'b0001, 4'b0000);
        tick(1);
        expect_b("b_step_clear", 4'b0001, 4'b0000, 4'b0000);
        din_b = 4'b0000;
        tick(4);
        expect_b("b_step_fall", 4'b0000, 4'b0000, 4'b0001);
        tick(2);

        // Second instance: a one-cycle glitch is accepted
        din_b = 4'b0001;
        tick(1);
        din_b = 4'b0000;
        tick(2);
        expect_b("b_glitch_wait", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        expect_b("b_glitch_rise", 4'b0001, 4'b0001, 4'b0000);
        tick(1);
        expect_b("b_glitch_fall", 4'b0000, 4'b0000, 4'b0001);
        tick(1);
        expect_b("b_glitch_clear", 4'b0000, 4'b0000, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // One post-release idle cycle: level stays at the reset level and no pulses appear.
    task automatic expect_a_after(input int k);
        tick(1);
        expect_a($sformatf("post_release_%0d", k), 4'b0000, 4'b0000, 4'b0000);
    endtask

endmodule
